// File: rtl/round_timer.sv
// Round countdown timer: prescaled second counter with start/pause, low-time warning and end-of-game outputs.
// Optional score bonus input is enabled by defining ROUND_TIMER_BONUS_EN.
module round_timer #(
    parameter int CLK_HZ      = 1000000,
    parameter int TICK_HZ     = 1,
    parameter int CNT_W       = 8,
    parameter int DEFAULT_LEN = 30,
    parameter int WARN_AT     = 5
`ifdef ROUND_TIMER_BONUS_EN
    ,
    parameter int BONUS_SEC   = 2
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             pause,
    input  logic             load_en,
    input  logic [CNT_W-1:0] load_val,
`ifdef ROUND_TIMER_BONUS_EN
    input  logic             bonus,
`endif
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             tick,
    output logic             warn,
    output logic             game_end,
    output logic             end_pulse
);

    localparam int               DIV      = CLK_HZ / TICK_HZ;
    localparam int               PW       = $clog2(DIV);
    localparam logic [PW-1:0]    PRE_LAST = PW'(DIV - 1);
    localparam logic [CNT_W-1:0] LEN_RST  = CNT_W'(DEFAULT_LEN);
    localparam logic [CNT_W-1:0] WARN_LVL = CNT_W'(WARN_AT);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

`ifdef ROUND_TIMER_BONUS_EN
    localparam int BONUS_V = BONUS_SEC;
    logic bonus_s;
    assign bonus_s = bonus;
`else
    localparam int BONUS_V = 0;
    logic bonus_s;
    assign bonus_s = 1'b0;
`endif

    logic [1:0]       state_r;
    logic [1:0]       state_s;
    logic [CNT_W-1:0] len_r;
    logic [CNT_W-1:0] len_s;
    logic [PW-1:0]    pre_r;
    logic [PW-1:0]    pre_s;
    logic [CNT_W-1:0] count_s;
    logic             tick_s;
    logic             warn_s;
    logic             running_s;
    logic             game_end_s;
    logic             end_pulse_s;
    logic             load_ok_s;

    // Adds the bonus (minus one second when a tick coincides), saturating at the counter maximum.
    function automatic logic [CNT_W-1:0] sat_adj(input logic [CNT_W-1:0] c, input logic dec);
        logic [CNT_W+31:0] sum;
        sum = {32'd0, c} + (CNT_W+32)'(BONUS_V) - (CNT_W+32)'(dec);
        if (|sum[CNT_W+31:CNT_W]) begin
            sat_adj = {CNT_W{1'b1}};
        end else begin
            sat_adj = sum[CNT_W-1:0];
        end
    endfunction

    // Next-state logic; start overrides everything, and pause is checked before the prescaler wrap.
    always_comb begin
        state_s     = state_r;
        pre_s       = pre_r;
        count_s     = count;
        tick_s      = 1'b0;
        end_pulse_s = 1'b0;
        game_end_s  = game_end;
        load_ok_s   = load_en && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        if (load_ok_s) begin
            len_s = load_val;
        end else begin
            len_s = len_r;
        end

        if (start) begin
            pre_s = '0;
            if (len_s == '0) begin
                state_s     = ST_DONE;
                count_s     = '0;
                game_end_s  = 1'b1;
                end_pulse_s = 1'b1;
            end else begin
                state_s    = ST_RUN;
                count_s    = len_s;
                game_end_s = 1'b0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (load_ok_s) begin
                        count_s = load_val;
                    end else begin
                        count_s = count;
                    end
                end
                ST_RUN, ST_PAUSED: begin
                    if (pause) begin
                        state_s = ST_PAUSED;
                        if (bonus_s) begin
                            count_s = sat_adj(count, 1'b0);
                        end else begin
                            count_s = count;
                        end
                    end else begin
                        // Leaving PAUSED counts as an active cycle, so the prescaler resumes at once.
                        state_s = ST_RUN;
                        if (pre_r == PRE_LAST) begin
                            pre_s  = '0;
                            tick_s = 1'b1;
                            if (bonus_s) begin
                                count_s = sat_adj(count, 1'b1);
                            end else if (count <= CNT_W'(1)) begin
                                count_s     = '0;
                                state_s     = ST_DONE;
                                game_end_s  = 1'b1;
                                end_pulse_s = 1'b1;
                            end else begin
                                count_s = count - CNT_W'(1);
                            end
                        end else begin
                            pre_s = pre_r + PW'(1);
                            if (bonus_s) begin
                                count_s = sat_adj(count, 1'b0);
                            end else begin
                                count_s = count;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    count_s    = '0;
                    game_end_s = 1'b1;
                end
                default: begin
                    state_s = ST_IDLE;
                end
            endcase
        end

        running_s = (state_s == ST_RUN) || (state_s == ST_PAUSED);
        warn_s    = running_s && (count_s != '0) && (count_s <= WARN_LVL);
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            len_r     <= LEN_RST;
            pre_r     <= '0;
            count     <= LEN_RST;
            running   <= 1'b0;
            tick      <= 1'b0;
            warn      <= 1'b0;
            game_end  <= 1'b0;
            end_pulse <= 1'b0;
        end else begin
            state_r   <= state_s;
            len_r     <= len_s;
            pre_r     <= pre_s;
            count     <= count_s;
            running   <= running_s;
            tick      <= tick_s;
            warn      <= warn_s;
            game_end  <= game_end_s;
            end_pulse <= end_pulse_s;
        end
    end

endmodule

// File: tb/tb_round_timer.sv
// Self-checking bench for round_timer: vector table, corner-case sequences and a randomized model comparison.
module tb_round_timer;
    localparam int CLK_HZ      = 10;
    localparam int TICK_HZ     = 1;
    localparam int DIV         = CLK_HZ / TICK_HZ;
    localparam int CNT_W       = 8;
    localparam int DEFAULT_LEN = 3;
    localparam int WARN_AT     = 2;

    logic             clk;
    logic             rst;
    logic             start;
    logic             pause;
    logic             load_en;
    logic [CNT_W-1:0] load_val;
`ifdef ROUND_TIMER_BONUS_EN
    logic             bonus;
`endif
    logic [CNT_W-1:0] count;
    logic             running;
    logic             tick;
    logic             warn;
    logic             game_end;
    logic             end_pulse;

    round_timer #(
        .CLK_HZ(CLK_HZ),
        .TICK_HZ(TICK_HZ),
        .CNT_W(CNT_W),
        .DEFAULT_LEN(DEFAULT_LEN),
        .WARN_AT(WARN_AT)
`ifdef ROUND_TIMER_BONUS_EN
        , .BONUS_SEC(2)
`endif
    ) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .pause(pause),
        .load_en(load_en),
        .load_val(load_val),
`ifdef ROUND_TIMER_BONUS_EN
        .bonus(bonus),
`endif
        .count(count),
        .running(running),
        .tick(tick),
        .warn(warn),
        .game_end(game_end),
        .end_pulse(end_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    typedef struct {
        int n;
        bit s, p, le;
        int lv;
        int c;
        bit run, tk, w, ge, ep;
    } vec_t;
    vec_t vt[$];

    // Reference model: elapsed active cycles since start, seconds derived by division.
    int m_len, m_count, m_elapsed;
    bit m_active, m_ended, m_tick, m_endp, m_warn;

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int c, input bit run, input bit tk,
                             input bit w, input bit ge, input bit ep);
        chk({tag, ".count"}, int'(count), c);
        chk({tag, ".running"}, int'(running), int'(run));
        chk({tag, ".tick"}, int'(tick), int'(tk));
        chk({tag, ".warn"}, int'(warn), int'(w));
        chk({tag, ".game_end"}, int'(game_end), int'(ge));
        chk({tag, ".end_pulse"}, int'(end_pulse), int'(ep));
    endtask

    // Hold the inputs for n rising edges, then return to idle inputs at edge+1.
    task automatic apply(input bit s, input bit p, input bit le, input int lv, input int n);
        start    = s;
        pause    = p;
        load_en  = le;
        load_val = CNT_W'(lv);
        repeat (n) @(posedge clk);
        #1;
        start   = 1'b0;
        pause   = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    function automatic void add(input int n, input bit s, input bit p, input bit le, input int lv,
                                input int c, input bit run, input bit tk, input bit w,
                                input bit ge, input bit ep);
        vec_t v;
        v.n = n; v.s = s; v.p = p; v.le = le; v.lv = lv;
        v.c = c; v.run = run; v.tk = tk; v.w = w; v.ge = ge; v.ep = ep;
        vt.push_back(v);
    endfunction

    task automatic model_reset();
        m_len = DEFAULT_LEN; m_count = DEFAULT_LEN; m_elapsed = 0;
        m_active = 1'b0; m_ended = 1'b0; m_tick = 1'b0; m_endp = 1'b0; m_warn = 1'b0;
    endtask

    task automatic model_step(input bit s, input bit p, input bit le, input int lv);
        m_tick = 1'b0;
        m_endp = 1'b0;
        if (!m_active && le) begin
            m_len = lv;
            if (!m_ended) m_count = lv;
        end
        if (s) begin
            m_elapsed = 0;
            if (m_len == 0) begin
                m_active = 1'b0; m_ended = 1'b1; m_count = 0; m_endp = 1'b1;
            end else begin
                m_active = 1'b1; m_ended = 1'b0; m_count = m_len;
            end
        end else if (m_active && !p) begin
            m_elapsed++;
            if (m_elapsed % DIV == 0) begin
                m_tick  = 1'b1;
                m_count = m_len - m_elapsed / DIV;
                if (m_count == 0) begin
                    m_active = 1'b0; m_ended = 1'b1; m_endp = 1'b1;
                end
            end
        end
        m_warn = m_active && (m_count != 0) && (m_count <= WARN_AT);
    endtask

    initial begin
        bit rs, rp, rle;
        int rlv;
        rst = 1'b1; start = 1'b0; pause = 1'b0; load_en = 1'b0; load_val = '0;
`ifdef ROUND_TIMER_BONUS_EN
        bonus = 1'b0;
`endif
        #12;
        check_all("reset", DEFAULT_LEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        //  n  s p le lv   cnt run tk w ge ep
        add(1, 0,0,0, 0,   3, 0,0,0,0,0);
        add(1, 1,0,0, 0,   3, 1,0,0,0,0);
        add(9, 0,0,0, 0,   3, 1,0,0,0,0);
        add(1, 0,0,0, 0,   2, 1,1,1,0,0);
        add(1, 0,0,0, 0,   2, 1,0,1,0,0);
        add(9, 0,0,0, 0,   1, 1,1,1,0,0);
        add(9, 0,0,0, 0,   1, 1,0,1,0,0);
        add(1, 0,0,0, 0,   0, 0,1,0,1,1);
        add(1, 0,0,0, 0,   0, 0,0,0,1,0);
        add(5, 0,1,0, 0,   0, 0,0,0,1,0);
        add(1, 0,0,1, 0,   0, 0,0,0,1,0);
        add(1, 1,0,0, 0,   0, 0,0,0,1,1);
        add(1, 0,0,0, 0,   0, 0,0,0,1,0);
        add(1, 1,0,1, 5,   5, 1,0,0,0,0);
        add(10,0,0,0, 0,   4, 1,1,0,0,0);
        add(1, 1,1,0, 0,   5, 1,0,0,0,0);
        add(20,0,1,0, 0,   5, 1,0,0,0,0);
        add(9, 0,0,0, 0,   5, 1,0,0,0,0);
        add(1, 0,0,0, 0,   4, 1,1,0,0,0);
        add(1, 0,0,1, 1,   4, 1,0,0,0,0);
        add(1, 0,1,0, 0,   4, 1,0,0,0,0);
        add(9, 0,0,0, 0,   3, 1,1,0,0,0);
        add(20,0,0,0, 0,   1, 1,1,1,0,0);
        add(10,0,0,0, 0,   0, 0,1,0,1,1);
        add(1, 1,0,0, 0,   5, 1,0,0,0,0);
        for (int i = 0; i < vt.size(); i++) begin
            apply(vt[i].s, vt[i].p, vt[i].le, vt[i].lv, vt[i].n);
            check_all($sformatf("vec%0d", i), vt[i].c, vt[i].run, vt[i].tk, vt[i].w, vt[i].ge, vt[i].ep);
        end

        // Restart in the middle of a round reloads count and clears the prescaler.
        apply(0, 0, 0, 0, 15);
        check_all("restart.pre", 4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1, 0, 0, 0, 1);
        check_all("restart.start", 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(0, 0, 0, 0, 9);
        check_all("restart.t9", 5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(0, 0, 0, 0, 1);
        check_all("restart.t10", 4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-round, checked before any clock edge.
        do_reset();
        apply(1, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 12);
        check_all("arst.before", 2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #3 rst = 1'b1;
        #1;
        check_all("arst.async", DEFAULT_LEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        apply(0, 0, 0, 0, 3);
        check_all("arst.after", DEFAULT_LEN, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Zero-length round loaded in IDLE finishes immediately.
        apply(0, 0, 1, 0, 1);
        check_all("zero.load", 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        apply(1, 0, 0, 0, 1);
        check_all("zero.start", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        apply(0, 0, 0, 0, 1);
        check_all("zero.hold", 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

`ifdef ROUND_TIMER_BONUS_EN
        do_reset();
        apply(1, 0, 0, 0, 1);
        apply(0, 0, 0, 0, 29);
        check_all("bonus.pre", 1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        bonus = 1'b1;
        apply(0, 0, 0, 0, 1);
        bonus = 1'b0;
        check_all("bonus.tick", 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        apply(0, 0, 0, 0, 10);
        check_all("bonus.next", 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        do_reset();
        apply(0, 0, 1, 255, 1);
        apply(1, 0, 0, 0, 1);
        check_all("bonus.max0", 255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        bonus = 1'b1;
        apply(0, 0, 0, 0, 1);
        bonus = 1'b0;
        check_all("bonus.sat", 255, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        rp = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            rs  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 5) rp = ~rp;
            rle = ($urandom_range(0, 99) < 6);
            rlv = $urandom_range(0, 6);
            start = rs; pause = rp; load_en = rle; load_val = CNT_W'(rlv);
            @(posedge clk);
            model_step(rs, rp, rle, rlv);
            #1;
            check_all("rand", m_count, m_active, m_tick, m_warn, m_ended, m_endp);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/round_timer.md
Name: round_timer

Overview:
Parametrised successor to the single-shot game timer in tt_um_whack_a_mole. It counts game seconds down from a loadable round length, derived from the system clock by an internal prescaler. It supports start/restart, pause, a low-time warning and both level and pulse end-of-game outputs. It sits beside the game FSM and drives the display/score logic with count, warn and game_end.

Parameters:
CLK_HZ, 1000000, system clock frequency in Hz.
TICK_HZ, 1, count decrement rate in Hz; DIV = CLK_HZ/TICK_HZ, with DIV >= 2 required.
CNT_W, 8, width of count and load_val.
DEFAULT_LEN, 30, round length after reset; must fit in CNT_W.
WARN_AT, 5, warn asserts when count <= WARN_AT.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  synchronous pulse; (re)starts a round.
pause  input  1  level; freezes the timer while high.
load_en  input  1  latches load_val as the new round length.
load_val  input  CNT_W  round length in seconds.
count  output  CNT_W  seconds remaining.
running  output  1  high in RUN and PAUSED.
tick  output  1  one-cycle pulse on each decrement.
warn  output  1  low-time indicator.
game_end  output  1  level, held until start or rst.
end_pulse  output  1  one-cycle pulse on entry to DONE.

Behaviour:
- All outputs are registered. The FSM has four states: IDLE, RUN, PAUSED, DONE.
- Reset (asynchronous, any state):
  - state = IDLE; len = DEFAULT_LEN; count = DEFAULT_LEN; prescaler = 0.
  - running, tick, warn, game_end and end_pulse are all 0.
- Internal registers: len (CNT_W bits) and a prescaler of clog2(DIV) bits.
- load_en:
  - Honoured only in IDLE or DONE; len <= load_val.
  - In IDLE, count also shows load_val.
  - Ignored in RUN and PAUSED.
- start (any state):
  - Sets count <= len, prescaler <= 0, game_end <= 0, then state RUN.
  - running is high in the cycle after the start edge.
  - Simultaneous start and pause: start wins and the next state is RUN; pause is sampled again on the following cycle.
  - Simultaneous start and load_en in IDLE/DONE: the new load_val is used.
- start with len == 0: goes directly to DONE; game_end = 1; end_pulse fires for one cycle; count = 0.
- RUN:
  - The prescaler increments every cycle.
  - At DIV-1 the prescaler wraps to 0, tick pulses for one cycle, and count decrements.
  - The first tick comes exactly DIV cycles after the start edge.
- Transition to DONE:
  - Occurs on the tick where count goes 1 -> 0.
  - In that same registered cycle: count = 0, game_end = 1, end_pulse = 1, running = 0.
  - count never wraps below 0.
- RUN with pause high: next state PAUSED. Prescaler and count are frozen, no ticks occur, and running stays 1.
- PAUSED with pause low: returns to RUN and the prescaler resumes from its frozen value.
- Pause versus tick in the same cycle: pause takes effect first, so the tick is suppressed.
- DONE: count holds 0 and game_end holds 1. Only start or rst leaves DONE; pause is ignored.
- warn = running & (count != 0) & (count <= WARN_AT), registered alongside count.
- rst mid-round aborts immediately. No end_pulse is generated.

Optional Feature:
Macro ROUND_TIMER_BONUS_EN.
- Defined:
  - Adds input port bonus (1 bit, pulse) and parameter BONUS_SEC (default 2).
  - In RUN or PAUSED, count <= count + BONUS_SEC, saturating at 2^CNT_W-1.
  - When bonus coincides with a tick, count <= sat(count - 1 + BONUS_SEC), and that tick cannot end the round.
  - bonus is ignored in IDLE and DONE.
- Undefined: the port and parameter are absent, and behaviour is exactly as above.

Test Plan:
All scenarios use CLK_HZ=10, TICK_HZ=1 (so DIV=10), DEFAULT_LEN=3, WARN_AT=2.
- Reset then start: count 3 -> 2 at cycle 10, 1 at cycle 20, 0 at cycle 30. tick pulses at 10/20/30. warn is high from cycle 10 to 29. At cycle 30: game_end = 1, one-cycle end_pulse, running = 0.
- load_en with load_val = 0 in IDLE, then start: next cycle DONE, count = 0, end_pulse for 1 cycle, no tick.
- Start, pause high at cycle 5 for 20 cycles: no tick during the pause; the first tick lands at cycle 30; count stays 3 while paused.
- Start at cycle 15 of a running round: count reloads to 3, prescaler clears, next tick at start+10. In DONE, start clears game_end and restarts.
- Assert rst asynchronously mid-RUN (count = 2): outputs go to reset values without waiting for a clock edge; count = 3; no end_pulse.
- ROUND_TIMER_BONUS_EN, BONUS_SEC=2:
  - bonus at count = 1, coincident with a tick: count = 2, game not ended.
  - bonus with count = 255 (CNT_W=8): count saturates at 255.
